// File: rtl/spi_cmd_byte_rx_pkg.sv
// ---------------------------------------------------------------------------
// spi_cmd_byte_rx_pkg : RX state encodings, stats width and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_cmd_byte_rx_pkg;

  localparam int SPI_RX_CNT_WIDTH = 16;

  typedef enum logic [0:0] {
    SPI_RX_STATE_IDLE  = 1'b0,
    SPI_RX_STATE_SHIFT = 1'b1
  } spi_rx_state_t;

  function automatic logic [SPI_RX_CNT_WIDTH-1:0] sat_inc(
    input logic [SPI_RX_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_byte_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// spi_cmd_byte_rx_byte_fifo : byte FIFO with registered head and drop flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_cmd_byte_rx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW:0]      wr_next;
  logic [PW:0]      rd_next;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer separates the full and empty cases.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign wr_next = wr_ptr + {{PW{1'b0}}, do_push};
  assign rd_next = rd_ptr + {{PW{1'b0}}, do_pop};
  assign level   = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (do_push || do_pop) begin
        // The new head may be the very entry being written this cycle.
        head       <= (do_push && (rd_next == wr_ptr)) ? push_data : mem[rd_next[PW-1:0]];
        head_valid <= (wr_next != rd_next);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_byte_rx.sv
// ---------------------------------------------------------------------------
// spi_cmd_byte_rx : SPI-slave (mode 0) byte receiver feeding a byte FIFO.
// Optional stats counters: define SPI_CMD_RX_STATS_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_cmd_byte_rx
  import spi_cmd_byte_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_sclk,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic [7:0]                    out_byte,
  output logic                          out_ready,
  input  logic                          next,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          frame_error,
  output logic [SPI_RX_CNT_WIDTH-1:0]   ovf_count,
  output logic [SPI_RX_CNT_WIDTH-1:0]   ferr_count
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  spi_rx_state_t          state;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             byte_next;
  logic                   push;
  logic [7:0]             push_data;
  logic                   drop;

  // Synchronisers deliberately ignore reset so edges stay clean across it.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev <= sclk_s;
    cs_prev   <= cs_s;
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign byte_next = {shreg, mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SPI_RX_STATE_IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 7'd0;
      push        <= 1'b0;
      push_data   <= 8'd0;
      frame_error <= 1'b0;
    end else begin
      push        <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        SPI_RX_STATE_IDLE: begin
          bit_cnt <= 3'd0;
          if (cs_fall) begin
            state <= SPI_RX_STATE_SHIFT;
          end
        end
        SPI_RX_STATE_SHIFT: begin
          if (cs_rise) begin
            state   <= SPI_RX_STATE_IDLE;
            bit_cnt <= 3'd0;
            if (bit_cnt != 3'd0) begin
              frame_error <= 1'b1;
            end
          end else if (sclk_rise) begin
            shreg <= byte_next[6:0];
            if (bit_cnt == 3'd7) begin
              push      <= 1'b1;
              push_data <= byte_next;
              bit_cnt   <= 3'd0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: state <= SPI_RX_STATE_IDLE;
      endcase
    end
  end

  spi_cmd_byte_rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (next),
    .head       (out_byte),
    .head_valid (out_ready),
    .level      (fill_level),
    .drop       (drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
    end
  end

`ifdef SPI_CMD_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count  <= '0;
      ferr_count <= '0;
    end else begin
      if (overflow) begin
        ovf_count <= sat_inc(ovf_count);
      end
      if (frame_error) begin
        ferr_count <= sat_inc(ferr_count);
      end
    end
  end
`else
  assign ovf_count  = '0;
  assign ferr_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_byte_rx : directed self-checking bench for spi_cmd_byte_rx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_cmd_byte_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [7:0]  out_byte;
  logic        out_ready;
  logic        next;
  logic [4:0]  fill_level;
  logic        overflow;
  logic        frame_error;
  logic [15:0] ovf_count;
  logic [15:0] ferr_count;

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;
  int ferr_pulses = 0;

`ifdef SPI_CMD_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_cmd_byte_rx #(
    .FIFO_DEPTH  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .out_byte    (out_byte),
    .out_ready   (out_ready),
    .next        (next),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .frame_error (frame_error),
    .ovf_count   (ovf_count),
    .ferr_count  (ferr_count)
  );

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_pulses++;
    if (frame_error === 1'b1) ferr_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit: sclk low phase then high phase of 4 clk cycles each.
  // With pop_sync set, next is pulsed in the cycle the completed byte
  // reaches the FIFO (two sync stages plus one edge-detect register).
  task automatic send_bits(input logic [7:0] d, input int n, input bit pop_sync);
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[7-i];
      wait_neg(4);
      spi_sclk = 1'b1;
      if (pop_sync && i == n - 1) begin
        wait_neg(3);
        next = 1'b1;
        wait_neg(1);
        next = 1'b0;
      end else begin
        wait_neg(4);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_neg(6);
  endtask

  task automatic cs_high();
    wait_neg(4);
    spi_cs_n = 1'b1;
    wait_neg(8);
  endtask

  task automatic pop_one();
    next = 1'b1;
    wait_neg(1);
    next = 1'b0;
  endtask

  int ovf0, ferr0;
  logic [7:0] b;

  initial begin
    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; next = 1'b0;
    wait_neg(10);
    chk("reset_out_byte", {24'd0, out_byte}, 32'h00);
    chk("reset_out_ready", {31'd0, out_ready}, 32'd0);
    chk("reset_fill", {27'd0, fill_level}, 32'd0);
    chk("reset_ovf_count", {16'd0, ovf_count}, 32'd0);
    chk("reset_ferr_count", {16'd0, ferr_count}, 32'd0);
    reset = 1'b0;
    wait_neg(4);

    // 1: two bytes, controller pops
    cs_low();
    send_bits(8'hA5, 8, 1'b0);
    send_bits(8'h3C, 8, 1'b0);
    cs_high();
    chk("t1_fill", {27'd0, fill_level}, 32'd2);
    chk("t1_ready", {31'd0, out_ready}, 32'd1);
    chk("t1_byte0", {24'd0, out_byte}, 32'hA5);
    pop_one();
    chk("t1_byte1", {24'd0, out_byte}, 32'h3C);
    chk("t1_ready1", {31'd0, out_ready}, 32'd1);
    pop_one();
    chk("t1_ready_empty", {31'd0, out_ready}, 32'd0);
    chk("t1_fill_empty", {27'd0, fill_level}, 32'd0);

    // 2: overflow with 18 bytes, no pops
    ovf0 = ovf_pulses;
    cs_low();
    for (int i = 0; i < 18; i++) send_bits(8'(i), 8, 1'b0);
    cs_high();
    chk("t2_fill", {27'd0, fill_level}, 32'd16);
    chk("t2_ovf_pulses", ovf_pulses - ovf0, 32'd2);
    chk("t2_ovf_count", {16'd0, ovf_count}, STATS ? 32'd2 : 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t2_pop_byte", {24'd0, out_byte}, i);
      pop_one();
    end
    chk("t2_ready_empty", {31'd0, out_ready}, 32'd0);

    // 3: frame error after 5 bits, then a clean frame
    ferr0 = ferr_pulses;
    cs_low();
    send_bits(8'hA8, 5, 1'b0);
    cs_high();
    chk("t3_ferr_pulses", ferr_pulses - ferr0, 32'd1);
    chk("t3_ferr_count", {16'd0, ferr_count}, STATS ? 32'd1 : 32'd0);
    chk("t3_no_push", {27'd0, fill_level}, 32'd0);
    cs_low();
    send_bits(8'h7E, 8, 1'b0);
    cs_high();
    chk("t3_byte", {24'd0, out_byte}, 32'h7E);
    chk("t3_fill", {27'd0, fill_level}, 32'd1);
    chk("t3_ferr_once", ferr_pulses - ferr0, 32'd1);
    pop_one();

    // 4: full FIFO, pop coincides with push
    ovf0 = ovf_pulses;
    cs_low();
    for (int i = 0; i < 16; i++) send_bits(8'h80 + 8'(i), 8, 1'b0);
    send_bits(8'hC3, 8, 1'b1);
    cs_high();
    chk("t4_fill", {27'd0, fill_level}, 32'd16);
    chk("t4_no_ovf", ovf_pulses - ovf0, 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk("t4_pop_byte", {24'd0, out_byte}, 32'h80 + i);
      pop_one();
    end
    chk("t4_tail", {24'd0, out_byte}, 32'hC3);
    pop_one();
    chk("t4_empty", {31'd0, out_ready}, 32'd0);

    // 5: reset mid-byte with 3 bytes queued
    cs_low();
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    send_bits(8'h33, 8, 1'b0);
    send_bits(8'hF0, 4, 1'b0);
    chk("t5_pre_fill", {27'd0, fill_level}, 32'd3);
    reset = 1'b1;
    wait_neg(4);
    reset = 1'b0;
    wait_neg(1);
    chk("t5_ready", {31'd0, out_ready}, 32'd0);
    chk("t5_fill", {27'd0, fill_level}, 32'd0);
    chk("t5_ovf_count_clr", {16'd0, ovf_count}, 32'd0);
    cs_high();
    cs_low();
    send_bits(8'h42, 8, 1'b0);
    cs_high();
    chk("t5_byte", {24'd0, out_byte}, 32'h42);
    chk("t5_fill_after", {27'd0, fill_level}, 32'd1);
    pop_one();

    // 6: pop while empty changes nothing
    b = out_byte;
    ovf0 = ovf_pulses;
    ferr0 = ferr_pulses;
    pop_one();
    wait_neg(2);
    chk("t6_byte", {24'd0, out_byte}, {24'd0, b});
    chk("t6_ready", {31'd0, out_ready}, 32'd0);
    chk("t6_fill", {27'd0, fill_level}, 32'd0);
    chk("t6_pulses", (ovf_pulses - ovf0) + (ferr_pulses - ferr0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
